// File: rtl/data_mem_pm.sv
// data_mem_pm: single-port data memory for the MEM stage.
// Byte-lane writes, registered reads with valid flag, selectable read-during-write,
// out-of-range flagging, and a reset-time sequencer that clears and preloads the array.
module data_mem_pm #(
    parameter int DW       = 16,
    parameter int AW       = 8,
    parameter int DEPTH    = 256,
    parameter int NBE      = DW / 8,
    parameter int INIT_VAL = 0,
    parameter int PRELOAD  = 1,
    parameter int RDW_NEW  = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           dwe,
    input  logic [NBE-1:0] dbe,
    input  logic           re,
    input  logic [AW-1:0]  addr,
    input  logic [DW-1:0]  wdata,
    output logic [DW-1:0]  rdata,
    output logic           rvalid,
    output logic           ready,
    output logic           err
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t         state;
    logic [AW-1:0]  ptr;
    logic [DW-1:0]  mem [DEPTH];

    logic           in_range;
    logic [AW-1:0]  idx;
    logic [DW-1:0]  old_word;
    logic [DW-1:0]  merged;
    logic [DW-1:0]  rd_word;
    logic [DW-1:0]  init_word;
    logic           run;

    assign run      = (state == S_RUN);
    assign in_range = ({1'b0, addr} < DEPTH_X);
    // Out-of-range addresses are steered to word 0 so the array is never indexed past its end.
    assign idx      = in_range ? addr : '0;
    assign old_word = mem[idx];

    // Per-lane merge: enabled lanes take wdata, others keep the stored byte.
    for (genvar i = 0; i < NBE; i++) begin : g_lane
        assign merged[8*i +: 8] = dbe[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
    end

    // Same-address read-during-write returns either the old word or the merged word.
    assign rd_word = (RDW_NEW != 0 && dwe) ? merged : old_word;

    // Value the init sequencer writes at the current pointer.
    always_comb begin
        init_word = DW'(INIT_VAL);
        if (PRELOAD != 0) begin
            if (ptr == AW'(1)) init_word = DW'(8'h0A);
            if (ptr == AW'(2)) init_word = DW'(8'h0B);
            if (ptr == AW'(3)) init_word = DW'(8'h0C);
        end
    end

    // Storage: init sequencer owns the array until RUN, then in-range writes.
    always_ff @(posedge clk) begin
        if (!run)
            mem[ptr] <= init_word;
        else if (dwe && in_range)
            mem[idx] <= merged;
    end

    // Init sequencer: one word per clock, ready asserted on the edge that writes the last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_INIT;
            ptr   <= '0;
            ready <= 1'b0;
        end else if (!run) begin
            ptr <= ptr + AW'(1);
            if (ptr == LAST) begin
                state <= S_RUN;
                ready <= 1'b1;
            end
        end
    end

    // Read port and error pulse; everything is held quiet while initialising.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            if (run) begin
                err <= (dwe | re) & ~in_range;
                if (re) begin
                    if (in_range) begin
                        rdata  <= rd_word;
                        rvalid <= 1'b1;
                    end else begin
                        rdata  <= '0;
                    end
                end
            end
        end
    end

endmodule
